avalon_read_master: RTL and testbench
=====================================

// Module: avalon_read_master
// PURPOSE
//  Avalon-MM pipelined read initiator; counterpart of the SRAM Avalon slave.
//  Given a base word address and a length, issues back-to-back single-word reads.
//  Honours waitrequest, collects readdatavalid responses in a local FIFO and
//  presents them on a valid/ready stream. Feeds pixel data to the processing pipeline.
//  Credit based: never has more reads in flight than free FIFO slots.
// PARAMETERS
//  ADDR_WIDTH  32  Avalon word-address width (slave uses address[17:0])
//  DATA_WIDTH  16  readdata / stream width
//  LEN_WIDTH   18  transfer length field width, in words
//  FIFO_DEPTH  4   response buffer depth = max reads outstanding (power of 2, >=2)
//  TIMEOUT     255 waitrequest stall limit in cycles (AVALON_RD_TIMEOUT_EN only)
// PORTS
//  clk            in   1           clock
//  rst_n          in   1           asynchronous active-low reset
//  start          in   1           1-cycle command strobe; sampled only in IDLE
//  base_address   in   ADDR_WIDTH  first word address, sampled with start
//  length         in   LEN_WIDTH   number of words, sampled with start
//  busy           out  1           high from the cycle after an accepted start until done
//  done           out  1           1-cycle pulse at transfer completion
//  error          out  1           sticky timeout flag, cleared by next start
//  address        out  ADDR_WIDTH  Avalon address
//  read_n         out  1           Avalon read, active-low
//  byteEnable_n   out  2           Avalon byte enables, active-low; 2'b00 while reading
//  waitrequest    in   1           slave stall
//  readData       in   DATA_WIDTH  slave read data
//  readdatavalid  in   1           slave response strobe
//  out_data       out  DATA_WIDTH  stream data (FIFO head)
//  out_valid      out  1           stream valid
//  out_ready      in   1           stream ready
// BEHAVIOUR
//  Reset values: read_n=1, address=0, byteEnable_n=2'b11, busy=0, done=0, error=0, out_valid=0.
//  All counters and the FIFO are cleared. Reset mid-transfer abandons it. Responses arriving after reset are dropped.
//  FSM: IDLE -start-> ISSUE (len>0) or DONE (len=0); ISSUE -last read accepted-> DRAIN;
//   DRAIN -outstanding=0 & FIFO empty-> DONE; DONE -> IDLE (done=1 in DONE for exactly 1 cycle).
//  start outside IDLE is ignored. The transfer is not altered.
//  Latency: start at cycle N -> read_n=0 with address=base at N+1 (registered outputs).
//  Accept = !read_n & !waitrequest. On accept: address+=1 (wraps mod 2^ADDR_WIDTH), issued+=1.
//   Also outstanding+=1.
//  While waitrequest=1, address/read_n/byteEnable_n held stable (Avalon rule).
//  Issue permitted only when outstanding + fifo_count < FIFO_DEPTH. Otherwise read_n=1.
//   Read_n is never deasserted while a read is stalled by waitrequest.
//  readdatavalid: push readData into FIFO, outstanding-=1. Same-cycle accept+response nets 0.
//  Credit rule guarantees no FIFO overflow. A response with outstanding=0 is dropped and ignored.
//  Stream: out_valid = !fifo_empty; pop on out_valid & out_ready. Push and pop in the same cycle are legal.
//   Also legal when the FIFO is full.
//  Back-to-back throughput: 1 read/cycle with waitrequest=0, out_ready=1, FIFO_DEPTH>=3-cycle slave latency.
//  Counters are LEN_WIDTH wide; length=2^LEN_WIDTH-1 must complete without overflow.
// CONFIGURATION
//  AVALON_RD_TIMEOUT_EN defined: stall counter counts consecutive cycles with !read_n & waitrequest.
//   On reaching TIMEOUT: read_n=1, error=1, FSM -> DRAIN (waits for outstanding responses), then DONE.
//  Undefined: no counter. error tied 0. Master waits on waitrequest indefinitely.
// STRUCTURE
//  Package avalon_rd_pkg: rd_state_t enum {IDLE, ISSUE, DRAIN, DONE}. BE_ALL_N=2'b00, BE_NONE_N=2'b11.
//  Sub-module avalon_rd_resp_fifo: DATA_WIDTH x FIFO_DEPTH sync FIFO with async active-low reset.
//   Ports: push, pop, full, empty, count.
//  Top holds FSM, address/issue/outstanding counters, timeout logic.
// TESTING
//  1 base=0x100, len=4, waitrequest=0, 1-cycle rdv latency, out_ready=1:
//    reads at 0x100..0x103 on 4 consecutive cycles, stream 4 words in order, done 1 cycle.
//  2 len=8, out_ready=0: exactly FIFO_DEPTH=4 reads issued then read_n=1.
//    Raise out_ready -> remaining 4 issued, all 8 delivered.
//  3 waitrequest=1 for 5 cycles on 2nd read: address/read_n stable throughout, no duplicate or skipped address.
//  4 len=0: done pulses cycle after start, read_n never asserted. Start during busy ignored.
//  5 rst_n low mid-transfer (2 outstanding): outputs at reset values immediately.
//    Late rdv ignored. New start works.
//  6 AVALON_RD_TIMEOUT_EN, TIMEOUT=16, waitrequest stuck 1: read_n=1 after 16 cycles, error=1, done pulses.
//    Next start clears error.

Source files
------------

// File: rtl/avalon_rd_pkg.sv
// avalon_rd_pkg: shared FSM state type and Avalon byte-enable constants for the read master
package avalon_rd_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} rd_state_t;
  localparam logic [1:0] BE_ALL_N  = 2'b00;
  localparam logic [1:0] BE_NONE_N = 2'b11;
endpackage

// File: rtl/avalon_read_master_if.sv
// avalon_read_master_if: Avalon-MM read bus between the read master and an SRAM slave
//  master modport: drives address, read_n, byteEnable_n; receives waitrequest, readData, readdatavalid
//  slave modport:  the mirror image
interface avalon_read_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] address;
  logic                  read_n;
  logic [1:0]            byteEnable_n;
  logic                  waitrequest;
  logic [DATA_WIDTH-1:0] readData;
  logic                  readdatavalid;
  modport master(output address, read_n, byteEnable_n, input waitrequest, readData, readdatavalid);
  modport slave(input address, read_n, byteEnable_n, output waitrequest, readData, readdatavalid);
endinterface

// File: rtl/avalon_rd_resp_fifo.sv
// avalon_rd_resp_fifo: DATA_WIDTH x FIFO_DEPTH synchronous FIFO buffering read responses
//  clk, rst_n (async active-low), push/din write side, pop/dout read side (dout = head),
//  full, empty, count (number of stored words). Push while full is taken only with a pop.
module avalon_rd_resp_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_WIDTH-1:0]         din,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign rd = pop && !empty;
  assign wr = push && (!full || rd);
  assign empty = count == '0;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(wr);
      rp <= rp + AW'(rd);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
endmodule

// File: rtl/avalon_read_master.sv
// avalon_read_master: Avalon-MM pipelined read initiator streaming responses out via valid/ready
//  clk, rst_n (async active-low); start/base_address/length command, busy/done/error status;
//  bus: Avalon master (address, read_n, byteEnable_n, waitrequest, readData, readdatavalid);
//  out_data/out_valid/out_ready response stream. Reads in flight never exceed free FIFO slots.
//  Optional AVALON_RD_TIMEOUT_EN: abort issuing after TIMEOUT consecutive stalled cycles, set error.
module avalon_read_master
  import avalon_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 18,
  parameter int FIFO_DEPTH = 4
`ifdef AVALON_RD_TIMEOUT_EN
  , parameter int TIMEOUT  = 255
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_address,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  avalon_read_master_if.master  bus,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  rd_state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [LEN_WIDTH-1:0] rem, rem_n;
  logic [CW-1:0] outst, outst_n, fcount, fcount_n;
  logic rd_n, rd_n_n, err, err_n;
  logic accept, stall, push, pop, full, empty, credit, timeout;
  assign accept = !rd_n && !bus.waitrequest;
  assign stall = !rd_n && bus.waitrequest;
  // a response with nothing outstanding is stale (e.g. from before a reset) and is dropped
  assign push = bus.readdatavalid && outst != '0;
  assign pop = !empty && out_ready;
  assign outst_n = outst + CW'(accept) - CW'(push);
  assign fcount_n = fcount + CW'(push) - CW'(pop);
  // credit looks at next-cycle occupancy so a newly presented read always owns a FIFO slot
  assign credit = !full && ({1'b0, outst_n} + {1'b0, fcount_n}) < (CW+1)'(FIFO_DEPTH);
`ifdef AVALON_RD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] stall_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cnt <= '0;
    else stall_cnt <= stall ? stall_cnt + 1'b1 : '0;
  assign timeout = stall && stall_cnt == TW'(TIMEOUT - 1);
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_n = state;
    addr_n = accept ? addr + 1'b1 : addr;
    rem_n = accept ? rem - 1'b1 : rem;
    rd_n_n = 1'b1;
    err_n = err | timeout;
    unique case (state)
      IDLE: if (start) begin
        state_n = length == '0 ? DONE : ISSUE;
        addr_n = base_address;
        rem_n = length;
        rd_n_n = length == '0;
        err_n = 1'b0;
      end
      ISSUE: begin
        if (timeout) state_n = DRAIN;
        else if (stall) rd_n_n = 1'b0;
        else if (rem_n == '0) state_n = DRAIN;
        else rd_n_n = !credit;
      end
      DRAIN: state_n = outst == '0 && empty ? DONE : DRAIN;
      DONE: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      rem <= '0;
      outst <= '0;
      rd_n <= 1'b1;
      err <= 1'b0;
    end else begin
      state <= state_n;
      addr <= addr_n;
      rem <= rem_n;
      outst <= outst_n;
      rd_n <= rd_n_n;
      err <= err_n;
    end
  avalon_rd_resp_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din(bus.readData),
    .dout(out_data),
    .full(full),
    .empty(empty),
    .count(fcount)
  );
  assign bus.address = addr;
  assign bus.read_n = rd_n;
  assign bus.byteEnable_n = rd_n ? BE_NONE_N : BE_ALL_N;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign error = err;
  assign out_valid = !empty;
endmodule

// File: tb/tb_avalon_read_master.sv
// tb_avalon_read_master: scoreboard bench driving a behavioural Avalon slave against the read master
module tb_avalon_read_master;
  logic clk = 1'b0;
  logic rst_n, start, busy, done, error, out_valid, out_ready;
  logic [31:0] base_address;
  logic [17:0] length;
  logic [15:0] out_data;
  int total = 0, bad = 0, cyc = 0;
  int acc_cnt, acc_first, acc_last, rd_low, stall_seen, stall_idx, stall_left, lat;
  bit stuck, prev_stall;
  logic [31:0] prev_addr;
  logic [31:0] exp_addr[$];
  logic [15:0] exp_data[$];
  logic [15:0] resp_dat[$];
  int resp_due[$];

  avalon_read_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(16)) bus();

  avalon_read_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(16), .LEN_WIDTH(18), .FIFO_DEPTH(4)
`ifdef AVALON_RD_TIMEOUT_EN
    , .TIMEOUT(16)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_address(base_address), .length(length),
    .busy(busy), .done(done), .error(error), .bus(bus.master),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [15:0] f(input logic [31:0] a);
    return a[15:0] ^ 16'h5A3C;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // slave model: samples on the falling edge, drives waitrequest/response for the next rising edge
  always @(negedge clk) begin
    bit stl;
    if (resp_due.size() != 0 && resp_due[0] <= cyc) begin
      bus.readdatavalid = 1'b1;
      bus.readData = resp_dat.pop_front();
      void'(resp_due.pop_front());
    end else begin
      bus.readdatavalid = 1'b0;
      bus.readData = 16'h0;
    end
    if (prev_stall && !stuck) check("stall_hold", {bus.read_n, bus.address}, {1'b0, prev_addr});
    stl = !bus.read_n && acc_cnt == stall_idx && stall_left > 0;
    bus.waitrequest = stuck || stl;
    if (stl) begin
      stall_left--;
      stall_seen++;
    end
    if (!bus.read_n) rd_low++;
    prev_stall = !bus.read_n && bus.waitrequest;
    prev_addr = bus.address;
    if (!bus.read_n && !bus.waitrequest) begin
      if (exp_addr.size() == 0) begin
        total++;
        bad++;
        $display("FAIL read_addr: got %0h required no read", bus.address);
      end else check("read_addr", bus.address, exp_addr.pop_front());
      check("byte_en", bus.byteEnable_n, 2'b00);
      resp_dat.push_back(f(bus.address));
      resp_due.push_back(cyc + lat);
      if (acc_cnt == 0) acc_first = cyc;
      acc_last = cyc;
      acc_cnt++;
    end
  end

  // stream monitor: every handshake must match the next expected word
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (exp_data.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stream_data: got %0h required no word", out_data);
      end else check("stream_data", out_data, exp_data.pop_front());
    end

  task automatic run(input logic [31:0] b, input logic [17:0] n, input bit expect_rd);
    @(posedge clk); #1;
    acc_cnt = 0; rd_low = 0; stall_seen = 0; acc_first = -1; acc_last = -1;
    if (expect_rd)
      for (int i = 0; i < int'(n); i++) begin
        exp_addr.push_back(b + i);
        exp_data.push_back(f(b + i));
      end
    start = 1'b1; base_address = b; length = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int i = 0;
    while (!done && i < lim) begin
      @(negedge clk);
      i++;
    end
    check("done_seen", done, 1'b1);
    @(negedge clk);
    check("done_pulse", done, 1'b0);
    check("addr_q_empty", exp_addr.size(), 0);
    check("data_q_empty", exp_data.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1; base_address = '0; length = '0;
    stuck = 1'b0; stall_idx = -1; stall_left = 0; lat = 1; prev_stall = 1'b0;
    acc_cnt = 0; rd_low = 0; stall_seen = 0;
    repeat (3) @(negedge clk);
    check("rst_read_n", bus.read_n, 1'b1);
    check("rst_address", bus.address, 32'h0);
    check("rst_be", bus.byteEnable_n, 2'b11);
    check("rst_status", {busy, done, error, out_valid}, 4'b0000);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: four back-to-back reads
    run(32'h100, 4, 1'b1);
    @(negedge clk);
    check("t1_first_read", {bus.read_n, bus.address}, {1'b0, 32'h100});
    check("t1_busy", busy, 1'b1);
    wait_done(50);
    check("t1_reads", acc_cnt, 4);
    check("t1_consecutive", acc_last - acc_first, 3);

    // 2: credit limit with a blocked stream
    out_ready = 1'b0;
    run(32'h2000, 8, 1'b1);
    repeat (20) @(negedge clk);
    check("t2_credit_reads", acc_cnt, 4);
    check("t2_read_n_idle", bus.read_n, 1'b1);
    check("t2_valid", out_valid, 1'b1);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_done(100);
    check("t2_reads", acc_cnt, 8);

    // 3: 5-cycle stall on the second read
    stall_idx = 1; stall_left = 5;
    run(32'h300, 4, 1'b1);
    wait_done(100);
    check("t3_stall_cycles", stall_seen, 5);
    check("t3_reads", acc_cnt, 4);
    stall_idx = -1;

    // 4: zero length, then start while busy
    run(32'h400, 0, 1'b1);
    @(negedge clk);
    check("t4_done_next", done, 1'b1);
    @(negedge clk);
    check("t4_done_once", done, 1'b0);
    check("t4_no_read", rd_low, 0);
    run(32'h500, 3, 1'b1);
    @(posedge clk); #1;
    start = 1'b1; base_address = 32'h900; length = 18'd5;
    @(posedge clk); #1 start = 1'b0;
    wait_done(100);
    check("t4_ignored_start", acc_cnt, 3);
    repeat (4) @(negedge clk);
    check("t4_idle_after", busy, 1'b0);

    // 5: reset with two reads outstanding, late responses must vanish
    lat = 3; out_ready = 1'b0;
    run(32'h600, 6, 1'b1);
    for (int i = 0; i < 50 && acc_cnt < 2; i++) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_addr.delete();
    exp_data.delete();
    #1;
    check("t5_rst_read_n", bus.read_n, 1'b1);
    check("t5_rst_address", bus.address, 32'h0);
    check("t5_rst_status", {busy, done, error, out_valid}, 4'b0000);
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("t5_late_dropped", out_valid, 1'b0);
    lat = 1;
    run(32'h700, 3, 1'b1);
    wait_done(100);
    check("t5_restart_reads", acc_cnt, 3);
`ifdef AVALON_RD_TIMEOUT_EN
    // 6: waitrequest stuck high
    stuck = 1'b1;
    run(32'h800, 4, 1'b0);
    wait_done(100);
    check("t6_read_n_cycles", rd_low, 16);
    check("t6_error", error, 1'b1);
    check("t6_no_accept", acc_cnt, 0);
    @(posedge clk); #1 stuck = 1'b0;
    run(32'h880, 2, 1'b1);
    @(negedge clk);
    check("t6_error_clear", error, 1'b0);
    wait_done(100);
`else
    check("error_tied", error, 1'b0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
